// File: rtl/array_mul_pkg.sv
// Shared constants and helpers for the pipelined array multiplier.
// The stage payload struct is declared inside array_mul_pipe, where WIDTH is known.
package array_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/array_mul_row.sv
// Adds one masked partial-product row (a & b[ROW]) << ROW to a running sum
// with a ripple-carry full-adder chain. Purely combinational.
module array_mul_row
    import array_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int ROW         = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               b_bit,
    input  logic               mode,
    input  logic [2*WIDTH-1:0] psum_in,
    output logic [2*WIDTH-1:0] psum_out
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] keep_mask;
    logic [PW-1:0] row_bits;
    logic          carry;

    always_comb begin
        keep_mask = '1;
        // Approximate mode drops every product column below APPROX_COLS.
        if (mode == MODE_APPROX) begin
            keep_mask = ~((PW'(1) << APPROX_COLS) - PW'(1));
        end
        row_bits = ({{WIDTH{1'b0}}, a & {WIDTH{b_bit}}} << ROW) & keep_mask;
    end

    always_comb begin
        psum_out = '0;
        carry    = 1'b0;
        for (int k = 0; k < PW; k++) begin
            psum_out[k] = psum_in[k] ^ row_bits[k] ^ carry;
            carry       = (psum_in[k] & row_bits[k]) | (carry & (psum_in[k] ^ row_bits[k]));
        end
    end

endmodule

// File: rtl/array_mul_pipe.sv
// Pipelined unsigned array multiplier: rows of the partial-product array are
// spread over STAGES register stages under a single global stall (advance).
module array_mul_pipe
    import array_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STAGES      = 4,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int R  = ceil_div(WIDTH, STAGES);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic [PW-1:0]    psum;
        logic             valid;
    } stage_t;

    stage_t        stage_q   [STAGES];
    stage_t        stage_d   [STAGES];
    stage_t        stage_in  [STAGES];
    logic [PW-1:0] stage_sum [STAGES];
    logic          advance;

    // Valid/ready: a transfer happens on any edge where valid & ready are both high.
    // The whole pipe shifts (bubbles included) whenever the output slot is free or drained.
    assign advance   = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stage_q[STAGES-1].valid;
    assign p         = stage_q[STAGES-1].psum;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [PW-1:0] chain [R+1];

        if (s == 0) begin : g_head
            assign stage_in[0] = '{a: a, b: b, mode: mode, psum: '0, valid: in_valid};
        end else begin : g_body
            assign stage_in[s] = stage_q[s-1];
        end

        assign chain[0] = stage_in[s].psum;

        for (genvar r = 0; r < R; r++) begin : g_row
            localparam int J = s * R + r;
            // The last stage may own fewer than R rows when WIDTH is not a multiple of STAGES.
            if (J < WIDTH) begin : g_add
                array_mul_row #(
                    .WIDTH       (WIDTH),
                    .APPROX_COLS (APPROX_COLS),
                    .ROW         (J)
                ) u_row (
                    .a        (stage_in[s].a),
                    .b_bit    (stage_in[s].b[J]),
                    .mode     (stage_in[s].mode),
                    .psum_in  (chain[r]),
                    .psum_out (chain[r+1])
                );
            end else begin : g_pass
                assign chain[r+1] = chain[r];
            end
        end

        assign stage_sum[s] = chain[R];
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s] = stage_q[s];
            if (advance) begin
                stage_d[s]      = stage_in[s];
                stage_d[s].psum = stage_sum[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

endmodule

// File: tb/tb_array_mul_pipe.sv
// Bench for array_mul_pipe (WIDTH=8, STAGES=4, APPROX_COLS=4): directed table,
// stall/reset sequences and a randomised stream checked against a reference model.
module tb_array_mul_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 4;
  localparam int AC     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*WIDTH-1:0] p;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] got_q[$];
  int                 got_cyc_q[$];
  logic               hold_pending = 1'b0;
  logic [2*WIDTH-1:0] held_p;

  typedef struct {
    logic [WIDTH-1:0]   va;
    logic [WIDTH-1:0]   vb;
    logic               vm;
    logic [2*WIDTH-1:0] vp;
  } vec_t;

  array_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .APPROX_COLS(AC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: exact product, or sum of surviving a[i]&b[j] bits by column weight
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic m);
    int unsigned acc;
    acc = 0;
    if (!m) begin
      acc = int'(x) * int'(y);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        for (int j = 0; j < WIDTH; j++)
          if (x[i] && y[j] && (i + j) >= AC) acc += (32'd1 << (i + j));
    end
    return acc[2*WIDTH-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_p", 32'(p), 32'(held_p));
      end
      hold_pending = out_valid && !out_ready;
      held_p       = p;
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b, mode));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else check("scoreboard_p", 32'(p), 32'(exp_q.pop_front()));
        got_q.push_back(p);
        got_cyc_q.push_back(cyc);
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  // driver: called at posedge+1; leaves in_valid high, returns at posedge+1 after accept
  task automatic drive_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tm,
                          output int acc_cyc);
    a = ta; b = tb_; mode = tm; in_valid = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) fail_now("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_output(input string name, input int acc_cyc, input logic [2*WIDTH-1:0] expv);
    int seen;
    seen = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) fail_now({name, "_timeout"});
    else begin
      check({name, "_latency"}, 32'(seen - acc_cyc), 32'(STAGES));
      check({name, "_p"}, 32'(p), 32'(expv));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int n);
    int ok;
    ok = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) fail_now({name, "_drain"});
    @(posedge clk); #1;
  endtask

  vec_t table_v[7];
  vec_t stream_v[6];
  logic [2*WIDTH-1:0] stall_exp[4];

  initial begin
    int acc_cyc;
    int n_acc;
    int k;
    int issued;
    logic acc;

    table_v[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
    table_v[1] = '{8'd15,  8'd15,  1'b0, 16'd225};
    table_v[2] = '{8'd15,  8'd15,  1'b1, 16'd176};
    table_v[3] = '{8'd0,   8'd200, 1'b0, 16'd0};
    table_v[4] = '{8'd0,   8'd200, 1'b1, 16'd0};
    table_v[5] = '{8'd200, 8'd0,   1'b1, 16'd0};
    table_v[6] = '{8'd255, 8'd255, 1'b1, 16'd64976};

    stream_v[0] = '{8'd3,   8'd5,   1'b0, 16'd15};
    stream_v[1] = '{8'd7,   8'd9,   1'b0, 16'd63};
    stream_v[2] = '{8'd255, 8'd1,   1'b0, 16'd255};
    stream_v[3] = '{8'd16,  8'd16,  1'b0, 16'd256};
    stream_v[4] = '{8'd100, 8'd200, 1'b0, 16'd20000};
    stream_v[5] = '{8'd15,  8'd15,  1'b1, 16'd176};

    stall_exp[0] = 16'd200; stall_exp[1] = 16'd231;
    stall_exp[2] = 16'd264; stall_exp[3] = 16'd299;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0;
    #3;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table, one op at a time
    out_ready = 1'b1;
    foreach (table_v[i]) begin
      drive_op(table_v[i].va, table_v[i].vb, table_v[i].vm, acc_cyc);
      in_valid = 1'b0;
      wait_output($sformatf("table%0d", i), acc_cyc, table_v[i].vp);
    end

    // back-to-back stream
    got_q.delete(); got_cyc_q.delete();
    foreach (stream_v[i]) drive_op(stream_v[i].va, stream_v[i].vb, stream_v[i].vm, acc_cyc);
    in_valid = 1'b0;
    wait_drain("stream", 6);
    check("stream_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check($sformatf("stream_p%0d", i), 32'(got_q[i]), 32'(stream_v[i].vp));
      if (i > 0) check($sformatf("stream_gap%0d", i), 32'(got_cyc_q[i] - got_cyc_q[i-1]), 32'd1);
    end

    // output stall with input held valid for 10 cycles
    got_q.delete(); got_cyc_q.delete();
    out_ready = 1'b0;
    k = 0; n_acc = 0;
    a = 8'd10; b = 8'd20; mode = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) n_acc++;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        a = 8'(10 + k); b = 8'(20 + k);
      end
    end
    check("stall_accepted", 32'(n_acc), 32'd4);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_p_held", 32'(p), 32'd200);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain("stall", 4);
    check("stall_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("stall_p%0d", i), 32'(got_q[i]), 32'(stall_exp[i]));
    check("stall_in_ready_back", 32'(in_ready), 32'd1);

    // asynchronous reset with three ops in flight
    out_ready = 1'b0;
    drive_op(8'd20, 8'd30, 1'b0, acc_cyc);
    drive_op(8'd40, 8'd50, 1'b1, acc_cyc);
    drive_op(8'd60, 8'd70, 1'b0, acc_cyc);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_p", 32'(p), 32'd0);
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_ghost_outputs", 32'(got_q.size()), 32'd0);
    drive_op(8'd12, 8'd12, 1'b0, acc_cyc);
    in_valid = 1'b0;
    wait_output("post_reset", acc_cyc, 16'd144);

    // randomised stream with random back-pressure
    issued = 0;
    for (int g = 0; g < 20000 && (issued < 3000 || in_valid); g++) begin
      if (!in_valid && issued < 3000 && $urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 7))
          0: a = '0;
          1: a = '1;
          default: a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        endcase
        case ($urandom_range(0, 7))
          0: b = '0;
          1: b = '1;
          default: b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        endcase
        mode = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        issued++;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("random", 0);
    check("random_issued", 32'(issued), 32'd3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
